// File: rtl/pattern_seq_ctrl.sv
// Frame-synchronous pattern selector for the test-pattern generator.
// Manual commands, next pulses and an auto-cycle timer are queued and applied only at vsync leading edges.
module pattern_seq_ctrl #(
  parameter int unsigned COCLOR_DEPP = 8,
  parameter int unsigned FRACT_BITS  = 12,
  parameter int unsigned H_ACT       = 1280,
  parameter bit          VS_POL      = 1'b1,
  parameter int unsigned INIT_TYPE   = 1,
  parameter bit          SEQ_INCL_0  = 1'b0,
  parameter int unsigned MAX_TYPE    = 4
) (
  input  logic                          pix_clk,
  input  logic                          rst,
  input  logic                          vs_in,
  input  logic                          auto_en,
  input  logic [15:0]                   hold_frames,
  input  logic                          next_req,
  input  logic                          cmd_valid,
  input  logic [7:0]                    cmd_type,
  output logic                          cmd_ready,
  output logic                          cmd_err,
  output logic [7:0]                    pattern_type,
  output logic [FRACT_BITS+COCLOR_DEPP-1:0] pattern_ramp_step,
  output logic                          update_pulse,
  output logic [15:0]                   frm_cnt
);

  localparam int unsigned       SW          = FRACT_BITS + COCLOR_DEPP;
  localparam longint unsigned   RAMP_STEP   = (64'd1 << SW) / H_ACT;
  localparam logic [SW-1:0]     RAMP_STEP_W = RAMP_STEP[SW-1:0];
  localparam logic [7:0]        INIT_T      = INIT_TYPE[7:0];
  localparam logic [7:0]        MAX_T       = MAX_TYPE[7:0];

  typedef enum logic {SRC_MAN, SRC_NXT} pend_src_t;

  logic       vs_d;
  logic       pend_valid;
  pend_src_t  pend_src;
  logic [7:0] pend_type;

  logic       va;
  logic       frame_start;
  logic       man_pending;
  logic       cmd_acc;
  logic       cmd_ok;
  logic [7:0] next_base;
  logic [15:0] hold_thr;

  function automatic logic [7:0] seq_next(input logic [7:0] t);
    if (SEQ_INCL_0)
      return (t < MAX_T) ? t + 8'd1 : 8'd0;
    else
      return (t >= 8'd1 && t < MAX_T) ? t + 8'd1 : 8'd1;
  endfunction

  always_comb begin
    va          = (vs_in == VS_POL);
    frame_start = va & ~vs_d;
    man_pending = pend_valid & (pend_src == SRC_MAN);
    cmd_acc     = cmd_valid & ~man_pending;
    cmd_ok      = (cmd_type <= MAX_T);
    next_base   = (pend_valid && pend_src == SRC_NXT) ? pend_type : pattern_type;
    hold_thr    = (hold_frames == 16'd0) ? 16'd0 : hold_frames - 16'd1;
  end

  assign cmd_ready = ~man_pending;

  always_ff @(posedge pix_clk) begin
    if (rst) begin
      vs_d              <= ~VS_POL;
      pend_valid        <= 1'b0;
      pend_src          <= SRC_NXT;
      pend_type         <= '0;
      pattern_type      <= INIT_T;
      pattern_ramp_step <= RAMP_STEP_W;
      update_pulse      <= 1'b0;
      cmd_err           <= 1'b0;
      frm_cnt           <= '0;
    end else begin
      vs_d         <= va;
      update_pulse <= 1'b0;
      cmd_err      <= cmd_acc & ~cmd_ok;

      if (frame_start) begin
        if (pend_valid) begin
          pattern_type <= pend_type;
          pend_valid   <= 1'b0;
          frm_cnt      <= '0;
          update_pulse <= 1'b1;
        end else if (auto_en && frm_cnt >= hold_thr) begin
          pattern_type <= seq_next(pattern_type);
          frm_cnt      <= '0;
          update_pulse <= 1'b1;
        end else if (frm_cnt != '1) begin
          frm_cnt <= frm_cnt + 16'd1;
        end
      end

      // New requests are written after the apply so a same-cycle request survives into the next frame
      if (cmd_acc) begin
        if (cmd_ok) begin
          pend_valid <= 1'b1;
          pend_src   <= SRC_MAN;
          pend_type  <= cmd_type;
        end
      end else if (next_req && !man_pending) begin
        pend_valid <= 1'b1;
        pend_src   <= SRC_NXT;
        pend_type  <= seq_next(next_base);
      end
    end
  end

endmodule

// File: tb/tb_pattern_seq_ctrl.sv
// Bench for pattern_seq_ctrl: scoreboarded pattern changes, a command/next vector table and reset/auto corner sequences.
module tb_pattern_seq_ctrl;

  logic        pix_clk = 1'b0;
  logic        rst;
  logic        vs_in;
  logic        auto_en;
  logic [15:0] hold_frames;
  logic        next_req;
  logic        cmd_valid;
  logic [7:0]  cmd_type;
  logic        cmd_ready;
  logic        cmd_err;
  logic [7:0]  pattern_type;
  logic [19:0] pattern_ramp_step;
  logic        update_pulse;
  logic [15:0] frm_cnt;

  always #5 pix_clk = ~pix_clk;

  pattern_seq_ctrl #(
    .COCLOR_DEPP(8), .FRACT_BITS(12), .H_ACT(1280), .VS_POL(1'b1),
    .INIT_TYPE(1), .SEQ_INCL_0(1'b0), .MAX_TYPE(4)
  ) dut (
    .pix_clk(pix_clk), .rst(rst), .vs_in(vs_in), .auto_en(auto_en),
    .hold_frames(hold_frames), .next_req(next_req), .cmd_valid(cmd_valid),
    .cmd_type(cmd_type), .cmd_ready(cmd_ready), .cmd_err(cmd_err),
    .pattern_type(pattern_type), .pattern_ramp_step(pattern_ramp_step),
    .update_pulse(update_pulse), .frm_cnt(frm_cnt)
  );

  typedef struct {
    logic [7:0]  cmd;
    bit          has_cmd;
    int unsigned nnext;
    logic [7:0]  exp_type;
    bit          exp_err;
    bit          exp_upd;
  } vec_t;

  vec_t       tbl [10];
  int         checks = 0;
  int         errors = 0;
  int         ph = 50;
  logic [7:0] exp_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One pixel clock; vsync is active for the first 5 cycles of each 100-cycle frame
  task automatic cyc();
    int pb;
    pb = ph;
    vs_in = (pb < 5);
    @(posedge pix_clk);
    #1;
    if (update_pulse === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_update: got type %0d expected no update", pattern_type);
      end else begin
        chk("sb_type", {24'd0, pattern_type}, {24'd0, exp_q.pop_front()});
        chk("sb_timing_phase", pb, 0);
      end
    end
    ph = (ph + 1) % 100;
  endtask

  task automatic run_frames(input int n);
    int f;
    f = 0;
    while (f < n) begin
      cyc();
      if (ph == 1) f++;
    end
  endtask

  initial begin
    tbl[0] = '{8'd3, 1'b1, 0, 8'd3, 1'b0, 1'b1};
    tbl[1] = '{8'd9, 1'b1, 0, 8'd3, 1'b1, 1'b0};
    tbl[2] = '{8'd4, 1'b1, 0, 8'd4, 1'b0, 1'b1};
    tbl[3] = '{8'd0, 1'b0, 3, 8'd3, 1'b0, 1'b1};
    tbl[4] = '{8'd2, 1'b1, 1, 8'd2, 1'b0, 1'b1};
    tbl[5] = '{8'd0, 1'b1, 0, 8'd0, 1'b0, 1'b1};
    tbl[6] = '{8'd0, 1'b0, 1, 8'd1, 1'b0, 1'b1};
    tbl[7] = '{8'd4, 1'b1, 0, 8'd4, 1'b0, 1'b1};
    tbl[8] = '{8'd5, 1'b1, 0, 8'd4, 1'b1, 1'b0};
    tbl[9] = '{8'd0, 1'b0, 1, 8'd1, 1'b0, 1'b1};

    rst = 1'b1; vs_in = 1'b0; auto_en = 1'b0; hold_frames = 16'd2;
    next_req = 1'b0; cmd_valid = 1'b0; cmd_type = 8'd0;
    repeat (3) cyc();
    rst = 1'b0;
    chk("rst_type", pattern_type, 1);
    chk("rst_ramp", pattern_ramp_step, 819);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_frm_cnt", frm_cnt, 0);
    chk("rst_update", update_pulse, 0);
    chk("rst_err", cmd_err, 0);

    run_frames(5);
    chk("idle_frm_cnt", frm_cnt, 5);
    chk("idle_type", pattern_type, 1);

    auto_en = 1'b1;
    exp_q.push_back(8'd2); exp_q.push_back(8'd3);
    exp_q.push_back(8'd4); exp_q.push_back(8'd1);
    run_frames(8);
    chk("auto_pending_left", exp_q.size(), 0);
    chk("auto_type", pattern_type, 1);
    chk("auto_frm_cnt", frm_cnt, 1);
    auto_en = 1'b0;

    for (int i = 0; i < 10; i++) begin
      while (ph != 50) cyc();
      for (int unsigned k = 0; k < tbl[i].nnext; k++) begin
        next_req = 1'b1; cyc();
        next_req = 1'b0; cyc();
      end
      if (tbl[i].has_cmd) begin
        chk($sformatf("tbl%0d_ready_before", i), cmd_ready, 1);
        cmd_valid = 1'b1; cmd_type = tbl[i].cmd;
        cyc();
        cmd_valid = 1'b0;
        chk($sformatf("tbl%0d_cmd_err", i), cmd_err, tbl[i].exp_err);
      end
      chk($sformatf("tbl%0d_ready_pending", i), cmd_ready,
          !(tbl[i].has_cmd && !tbl[i].exp_err));
      if (tbl[i].exp_upd) exp_q.push_back(tbl[i].exp_type);
      run_frames(1);
      chk($sformatf("tbl%0d_type", i), pattern_type, tbl[i].exp_type);
      if (tbl[i].exp_upd) chk($sformatf("tbl%0d_frm_cnt", i), frm_cnt, 0);
      chk($sformatf("tbl%0d_ready_after", i), cmd_ready, 1);
      chk($sformatf("tbl%0d_err_cleared", i), cmd_err, 0);
      chk($sformatf("tbl%0d_sb_drained", i), exp_q.size(), 0);
    end

    hold_frames = 16'd0; auto_en = 1'b1;
    exp_q.push_back(8'd2); exp_q.push_back(8'd3); exp_q.push_back(8'd4);
    run_frames(3);
    chk("hold0_type", pattern_type, 4);
    chk("hold0_drained", exp_q.size(), 0);

    auto_en = 1'b0;
    while (ph != 50) cyc();
    cmd_valid = 1'b1; cmd_type = 8'd3;
    cyc();
    cmd_valid = 1'b0;
    chk("pre_rst_ready", cmd_ready, 0);
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    chk("midrst_type", pattern_type, 1);
    chk("midrst_ready", cmd_ready, 1);
    chk("midrst_frm_cnt", frm_cnt, 0);
    run_frames(1);
    chk("midrst_no_apply_type", pattern_type, 1);
    chk("midrst_frm_cnt_after", frm_cnt, 1);

    hold_frames = 16'd3;
    run_frames(3);
    chk("auto_off_counting", frm_cnt, 4);
    auto_en = 1'b1;
    exp_q.push_back(8'd2);
    run_frames(1);
    chk("reassert_type", pattern_type, 2);
    chk("reassert_frm_cnt", frm_cnt, 0);
    chk("final_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_seq_ctrl.md
Name: pattern_seq_ctrl

Overview:
- Frame-synchronous controller that drives the pattern_type and pattern_ramp_step inputs of the test-pattern generator.
- Sources of a pattern change: a manual command (valid/ready handshake), a "next" pulse from a board button or UART, and an auto-cycle timer counted in frames.
- Every change is committed only at a frame start (vsync leading edge), so a frame is never split between two patterns.
- Sits between the video timing generator / control logic and the pattern generator, in the pix_clk domain.

Parameters:
- COCLOR_DEPP, 8, bits per colour channel
- FRACT_BITS, 12, fractional bits of the ramp step
- H_ACT, 1280, active pixels per line
- VS_POL, 1, vsync active level (1 = active-high)
- INIT_TYPE, 1, pattern_type after reset
- SEQ_INCL_0, 0, include type 0 (passthrough) in the cycle sequence
- MAX_TYPE, 4, highest legal pattern_type

Ports:
- pix_clk  in  1  pixel clock; the only clock
- rst  in  1  synchronous active-high reset
- vs_in  in  1  vsync from the timing generator, polarity set by VS_POL
- auto_en  in  1  enable auto-cycling
- hold_frames  in  16  frames per pattern in auto mode; 0 is treated as 1
- next_req  in  1  single-cycle pulse: advance to the next pattern in sequence
- cmd_valid  in  1  manual command valid
- cmd_type  in  8  manual pattern type requested
- cmd_ready  out  1  manual command may be accepted
- cmd_err  out  1  one-cycle pulse: accepted command was out of range
- pattern_type  out  8  to the pattern generator
- pattern_ramp_step  out  FRACT_BITS+COCLOR_DEPP  to the pattern generator
- update_pulse  out  1  one-cycle pulse when the outputs change
- frm_cnt  out  16  frames since the last applied change

Behaviour:
- Reset (rst=1 at a clock edge): pattern_type=INIT_TYPE; pattern_ramp_step=RAMP_STEP; update_pulse=0; cmd_err=0; cmd_ready=1; frm_cnt=0; pending state cleared; vs history reg set to inactive. Reset mid-frame discards any pending change.
- RAMP_STEP (localparam) = floor(2^(COCLOR_DEPP+FRACT_BITS) / H_ACT). Default is 819. pattern_ramp_step is constant after reset.
- Frame start detection:
  - va = (vs_in == VS_POL); vs_d is va registered.
  - frame_start = va & ~vs_d, computed combinationally in cycle N.
  - Any applied change is visible on outputs in cycle N+1, with update_pulse=1 in cycle N+1 only.
- Pending register holds {pend_valid, pend_src (MAN / NXT), pend_type}.
- Manual command:
  - cmd_ready = ~(pend_valid & pend_src==MAN).
  - On cmd_valid & cmd_ready with cmd_type ≤ MAX_TYPE: pend ← {1, MAN, cmd_type}, overwriting any NXT pending entry.
  - If cmd_type > MAX_TYPE: the command is consumed, the pending register is unchanged, and cmd_err=1 for one cycle.
- next_req:
  - Ignored if a MAN entry is pending.
  - Otherwise pend ← {1, NXT, next(base)}. base = pend_type if a NXT entry is already pending, else pattern_type. Consecutive pulses within one frame therefore advance multiple steps.
  - If cmd accept and next_req occur in the same cycle, the command wins and next_req is dropped.
- Sequence function next(t):
  - SEQ_INCL_0=0: 1→2→3→4→1; any t ∉ 1..MAX_TYPE → 1.
  - SEQ_INCL_0=1: 0→1→…→MAX_TYPE→0.
- At frame_start, priority order:
  1. If a change is pending: pattern_type ← pend_type; pend cleared; frm_cnt ← 0.
  2. Else if auto_en and frm_cnt ≥ max(hold_frames,1)−1: pattern_type ← next(pattern_type); frm_cnt ← 0.
  3. Else frm_cnt ← frm_cnt+1, saturating at 0xFFFF.
- update_pulse fires on any apply in steps 1–2, even if the new type equals the old one.
- A command accepted in the same cycle as frame_start is not applied until the next frame start. The pending register uses its pre-edge value.
- auto_en deassert: the timer stops deciding changes; frm_cnt keeps counting. Reasserting with frm_cnt already past the threshold causes a change at the next frame start.
- Manual and next requests work regardless of auto_en.

Test Plan:
- Reset, vs_in toggling with period 100 cycles, auto_en=0 → pattern_type=1, ramp_step=819, no update_pulse over 5 frames, frm_cnt=5.
- auto_en=1, hold_frames=2 → type sequence 1,2,3,4,1 changing every 2nd frame start; update_pulse 1 cycle after each vs leading edge.
- cmd_type=3 mid-frame → cmd_ready drops to 0; pattern_type=3 one cycle after the next vs edge; cmd_ready back to 1; frm_cnt=0.
- cmd_type=9 → cmd_err pulse, no pend, pattern_type unchanged next frame.
- From type 4, three next_req pulses in one frame → type 3 at the next frame start. Then one next_req plus cmd(2) in the same frame → type 2.
- hold_frames=0, auto_en=1 → type changes every frame. Assert rst mid-frame with pend active → type=1, no change at the following frame start.
